// File: rtl/sbox_thres_pipe.sv
// Forward AES S-box using composite-field GF((2^4)^2) inversion. Each nonlinear layer gets fresh shares
// and sits behind its own register. Valid/ready streaming at one byte per cycle.
module sbox_thres_pipe #(
  parameter int CNT_W     = 32,
  parameter bit ZERO_MASK = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [15:0]      r1,
  input  logic [23:0]      r2,
  input  logic [23:0]      r3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] op_count
);

  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // GF(2^4) with x^4 = x + 1
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [7:0] embed(input logic [3:0] n, input logic [7:0] xh);
    logic [7:0] e;
    logic [7:0] pw;
    e  = '0;
    pw = 8'h01;
    for (int i = 0; i < 4; i++) begin
      if (n[i]) e ^= pw;
      pw = gf8_mul(pw, xh);
    end
    return e;
  endfunction

  function automatic logic [7:0] phi(input logic [7:0] c, input logic [7:0] xh, input logic [7:0] yh);
    return gf8_mul(embed(c[7:4], xh), yh) ^ embed(c[3:0], xh);
  endfunction

  // Basis-change matrices, found at elaboration: xh is a root of x^4+x+1 and yh a root of
  // y^2+y+lambda (lambda = x^3+x^2) in the AES field. Low half maps AES->composite, high half back.
  function automatic logic [127:0] build_maps();
    logic [127:0] m;
    logic [7:0]   xh, yh, lam, vv, sq, p;
    m  = '0;
    xh = '0;
    yh = '0;
    for (int v = 255; v >= 2; v--) begin
      vv = 8'(v);
      sq = gf8_mul(vv, vv);
      if ((gf8_mul(sq, sq) ^ vv ^ 8'h01) == 8'h00) xh = vv;
    end
    lam = gf8_mul(xh, gf8_mul(xh, xh)) ^ gf8_mul(xh, xh);
    for (int v = 255; v >= 2; v--) begin
      vv = 8'(v);
      if ((gf8_mul(vv, vv) ^ vv ^ lam) == 8'h00) yh = vv;
    end
    for (int i = 0; i < 8; i++) m[64 + 8*i +: 8] = phi(8'(1 << i), xh, yh);
    for (int c = 0; c < 256; c++) begin
      p = phi(8'(c), xh, yh);
      for (int i = 0; i < 8; i++) if (p == 8'(1 << i)) m[8*i +: 8] = 8'(c);
    end
    return m;
  endfunction

  function automatic logic [7:0] lin_map(input logic [63:0] cols, input logic [7:0] a);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) if (a[i]) y ^= cols[8*i +: 8];
    return y;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  // Two-share multiply: returns {z1, z0} with z0 ^ z1 = (a0^a1)*(b0^b1); m refreshes both shares.
  function automatic logic [7:0] tm2(input logic [3:0] a0, input logic [3:0] a1,
                                     input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] m);
    return {gf4_mul(a1, b0) ^ gf4_mul(a1, b1) ^ m, gf4_mul(a0, b0) ^ gf4_mul(a0, b1) ^ m};
  endfunction

  function automatic logic [3:0] thres_mult(input logic [3:0] a, input logic [3:0] b, input logic [11:0] r);
    logic [7:0] z;
    z = tm2(r[3:0], a ^ r[3:0], r[7:4], b ^ r[7:4], r[11:8]);
    return z[7:4] ^ z[3:0];
  endfunction

  // x^14 = x^-1 in GF(2^4), built as x^2 * x^4 * x^8 on shares; squarings are linear per share.
  function automatic logic [3:0] thres_inv4(input logic [3:0] x, input logic [15:0] r);
    logic [3:0] x0, x1, s2_0, s2_1, s4_0, s4_1, s8_0, s8_1;
    logic [7:0] p, q;
    x0   = r[3:0];
    x1   = x ^ r[3:0];
    s2_0 = gf4_mul(x0, x0);     s2_1 = gf4_mul(x1, x1);
    s4_0 = gf4_mul(s2_0, s2_0); s4_1 = gf4_mul(s2_1, s2_1);
    s8_0 = gf4_mul(s4_0, s4_0); s8_1 = gf4_mul(s4_1, s4_1);
    p    = tm2(s2_0, s2_1, s4_0, s4_1, r[7:4]);
    q    = tm2(p[3:0] ^ r[15:12], p[7:4] ^ r[15:12], s8_0, s8_1, r[11:8]);
    return q[3:0] ^ q[7:4];
  endfunction

  localparam logic [127:0] MAPS      = build_maps();
  localparam logic [63:0]  TO_COMP   = MAPS[63:0];
  localparam logic [63:0]  FROM_COMP = MAPS[127:64];

  logic        stall, adv;
  logic [15:0] m1;
  logic [23:0] m2, m3;
  logic        s0_valid, s1_valid, s2_valid;
  logic [7:0]  s0_data;
  logic [15:0] s0_r1, s1_r1;
  logic [23:0] s0_r2, s0_r3, s1_r2, s2_r2;
  logic [3:0]  s1_delta, s1_ah, s1_al, s2_b, s2_ah, s2_al;
  logic [7:0]  comp, sub;
  logic [3:0]  ah, al, delta, b, d1, d0;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;
  assign m1 = ZERO_MASK ? '0 : r1;
  assign m2 = ZERO_MASK ? '0 : r2;
  assign m3 = ZERO_MASK ? '0 : r3;

  always_comb begin
    comp  = lin_map(TO_COMP, s0_data);
    ah    = comp[7:4];
    al    = comp[3:0];
    delta = gf4_mul(4'hc, gf4_mul(ah, ah)) ^ thres_mult(ah, al, s0_r3[11:0] ^ s0_r3[23:12])
          ^ gf4_mul(al, al);
    b     = thres_inv4(s1_delta, s1_r1);
    d1    = thres_mult(s2_ah, s2_b, s2_r2[11:0]);
    d0    = thres_mult(s2_ah ^ s2_al, s2_b, s2_r2[23:12]);
    sub   = affine(lin_map(FROM_COMP, {d1, d0}));
  end

  // NOTE: non-blocking assignments throughout so every stage samples the pre-edge value of the one before.
  always_ff @(posedge clock) begin
    if (reset) begin
      s0_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      op_count  <= '0;
    end else begin
      if (adv) begin
        s0_valid  <= in_valid;
        s1_valid  <= s0_valid;
        s2_valid  <= s1_valid;
        out_valid <= s2_valid;
        if (s2_valid) out_data <= sub;
      end
      if (out_valid && out_ready) op_count <= op_count + CNT_W'(1);
    end
  end

  // NOTE: datapath registers have no reset; the stage valid bits alone qualify their contents.
  always_ff @(posedge clock) begin
    if (adv) begin
      if (in_valid) begin
        s0_data <= in_data;
        s0_r1   <= m1;
        s0_r2   <= m2;
        s0_r3   <= m3;
      end
      s1_delta <= delta;
      s1_ah    <= ah;
      s1_al    <= al;
      s1_r1    <= s0_r1;
      s1_r2    <= s0_r2;
      s2_b     <= b;
      s2_ah    <= s1_ah;
      s2_al    <= s1_al;
      s2_r2    <= s1_r2;
    end
  end

endmodule

// File: tb/tb_sbox_thres_pipe.sv
// Bench for sbox_thres_pipe: randomized traffic against a GF(2^8)-arithmetic S-box model,
// with a second unmasked, 4-bit-counter instance fed the same stimulus.
module tb_sbox_thres_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;
  logic [15:0] r1;
  logic [23:0] r2, r3;
  logic [31:0] op_count;
  logic        zm_in_ready, zm_out_valid;
  logic [7:0]  zm_out_data;
  logic [3:0]  zm_op_count;

  sbox_thres_pipe #(.CNT_W(32), .ZERO_MASK(1'b0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .r1(r1), .r2(r2), .r3(r3), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .op_count(op_count));

  sbox_thres_pipe #(.CNT_W(4), .ZERO_MASK(1'b1)) dut_zm (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(zm_in_ready), .in_data(in_data),
    .r1(r1), .r2(r2), .r3(r3), .out_valid(zm_out_valid), .out_ready(out_ready),
    .out_data(zm_out_data), .op_count(zm_op_count));

  always #5 clock = ~clock;

  typedef struct packed { logic [7:0] din; logic [7:0] exp; } item_t;

  item_t      exp_q[$];
  logic [7:0] got_log[$];
  int         got_cyc[$];
  logic [7:0] sbox_ref [256];
  logic [7:0] inv_ref [256];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         out_cnt = 0;
  bit         last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // FIPS-197: multiplicative inverse as a^254 (0 -> 0), then bitwise affine with constant 0x63.
  function automatic logic [7:0] ref_sub(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    inv = 8'h01;
    c   = 8'h63;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  task automatic rand_masks(input bit zero);
    r1 = zero ? 16'h0 : 16'($urandom());
    r2 = zero ? 24'h0 : 24'($urandom());
    r3 = zero ? 24'h0 : 24'($urandom());
  endtask

  // One clock: score transfers that the coming edge will perform, then advance to the next falling edge.
  task automatic step();
    item_t it;
    #1;
    last_acc = 1'b0;
    if (!reset) begin
      if (out_valid && out_ready) begin
        check("zm_out_valid", 32'(zm_out_valid), 32'(out_valid));
        if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
        else begin
          it = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(it.exp));
          check("zm_out_data", 32'(zm_out_data), 32'(it.exp));
          check("inv_chain", 32'(inv_ref[out_data]), 32'(it.din));
          got_log.push_back(out_data);
          got_cyc.push_back(cyc);
          out_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        it.din = in_data;
        it.exp = sbox_ref[in_data];
        exp_q.push_back(it);
        last_acc = 1'b1;
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    reset   = 1'b0;
    exp_q.delete();
    out_cnt = 0;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && (exp_q.size() > 0 || out_valid); i++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] s_in [4];
    logic [7:0] s_out [4];
    logic [7:0] held;
    int         base;
    bit         acc;

    for (int v = 0; v < 256; v++) sbox_ref[v] = ref_sub(8'(v));
    for (int v = 0; v < 256; v++) inv_ref[sbox_ref[v]] = 8'(v);

    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; reset = 1'b1;
    rand_masks(1'b0);
    @(negedge clock);
    do_reset();

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_op_count", op_count, 32'd0);
    check("rst_zm_op_count", 32'(zm_op_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single byte 0x00: accepted at edge N, out_valid rises at edge N+3
    in_valid = 1'b1; in_data = 8'h00; rand_masks(1'b0);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("lat_early", 32'(out_valid), 32'd0);
      step();
    end
    check("lat_valid", 32'(out_valid), 32'd1);
    check("zero_byte", 32'(out_data), 32'h63);
    step();
    check("op_count_1", op_count, 32'd1);
    check("single_gone", 32'(out_valid), 32'd0);

    // Back-to-back stream with out_ready held high
    s_in  = '{8'h01, 8'h53, 8'hFF, 8'hC5};
    s_out = '{8'h7C, 8'hED, 8'h16, 8'hA6};
    got_log.delete(); got_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = s_in[i]; rand_masks(1'b0);
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    drain(20);
    check("stream_count", 32'(got_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_log.size(); i++) begin
      check("stream_fips", 32'(got_log[i]), 32'(s_out[i]));
      check("stream_consec", 32'(got_cyc[i]), 32'(got_cyc[0] + i));
    end

    // Backpressure: three bytes in flight, output held for 5 cycles
    out_ready = 1'b0;
    base = out_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom()); rand_masks(1'b0);
      step();
      check("bp_accept", 32'(last_acc), 32'd1);
    end
    in_valid = 1'b0;
    step();
    held = out_data;
    check("bp_first", 32'(held), 32'(exp_q.size() > 0 ? exp_q[0].exp : 8'h00));
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom()); rand_masks(1'b0);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_hold", 32'(out_data), 32'(held));
      step();
    end
    drain(20);
    check("bp_count", 32'(out_cnt - base), 32'd3);

    // All inputs, four random mask sets plus all-zero masks, random bubbles and backpressure
    for (int v = 0; v < 256; v++) begin
      for (int j = 0; j < 5; j++) begin
        if ($urandom_range(0, 7) == 0) begin
          in_valid = 1'b0;
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        in_valid = 1'b1; in_data = 8'(v); rand_masks(j == 4);
        acc = 1'b0;
        for (int t = 0; t < 64 && !acc; t++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
          acc = last_acc;
        end
        check("accept", 32'(acc), 32'd1);
      end
    end
    drain(40);
    check("sweep_op_count", op_count, 32'(out_cnt));
    check("sweep_zm_op_count", 32'(zm_op_count), 32'(out_cnt % 16));

    // Reset with two bytes in flight
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom()); rand_masks(1'b0);
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    out_cnt = 0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_op_count", op_count, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("no_stale", 32'(out_valid), 32'd0);
      step();
    end

    // Counter wrap on the 4-bit instance: 17 transfers
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom()); rand_masks(1'b0);
      step();
    end
    drain(20);
    check("wrap_op_count32", op_count, 32'd17);
    check("wrap_op_count4", 32'(zm_op_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
